arb_dual_port_ram: RTL and testbench

- Parametrised, synthesizable word-addressed RAM shared by two requestors: port A (core data side) and port B (LA/debug loader side).
- Single array; per-cycle round-robin arbitration; req/gnt/rvalid handshake; byte-lane write strobes; registered read data.
- Saturating contention counter exposed for logic-analyser visibility.
- Successor to the fixed 1024x32 single-master RAM in the user project wrapper; drops in for both instruction and data memory.

---
 rtl/arb_dual_port_ram.sv | 124 ++++++++++++
 tb/tb_arb_dual_port_ram.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/arb_dual_port_ram.sv
// Word-addressed RAM that two requestors share under round-robin arbitration, with byte strobes and registered reads.
// Define RAM_PARITY_EN to add per-byte even parity with fault injection on parity_inj_n.
module arb_dual_port_ram #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = $clog2(DEPTH),
    parameter string INIT_FILE = "",
    parameter int    CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [DATA_W/8-1:0]  a_be,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [DATA_W-1:0]    a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [DATA_W/8-1:0]  b_be,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [DATA_W-1:0]    b_rdata,
    output logic                 oob_err,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     conflict_cnt,
    output logic                 parity_err,
    input  logic                 parity_inj_n
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] ADDR_LIM = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic              prio_b;
    logic              gnt;
    logic              acc_we;
    logic [NB-1:0]     acc_be;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    // prio_b names the port that wins the next conflict; a single requestor always wins.
    always_comb begin
        a_gnt     = a_req & (~b_req | ~prio_b);
        b_gnt     = b_req & (~a_req | prio_b);
        gnt       = a_gnt | b_gnt;
        acc_we    = b_gnt ? b_we    : a_we;
        acc_be    = b_gnt ? b_be    : a_be;
        acc_addr  = b_gnt ? b_addr  : a_addr;
        acc_wdata = b_gnt ? b_wdata : a_wdata;
        in_range  = {1'b0, acc_addr} < ADDR_LIM;
    end

    assign rd_word = in_range ? mem[acc_addr] : '0;

    always_ff @(posedge clk) begin
        if (gnt && acc_we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (acc_be[i]) mem[acc_addr][i*8 +: 8] <= acc_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b       <= 1'b0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            oob_err      <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (a_req && b_req) prio_b <= ~prio_b;
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (a_gnt && !a_we) a_rdata <= rd_word;
            if (b_gnt && !b_we) b_rdata <= rd_word;
            if (gnt && !in_range) oob_err <= 1'b1;
            else if (err_clr)     oob_err <= 1'b0;
            if (a_req && b_req && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par;
    logic [NB-1:0] rd_par;
    logic          par_mismatch;

    // Parity bits are inverted while parity_inj_n is low, so a later read reports an error.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            wr_par[i] = (^acc_wdata[i*8 +: 8]) ^ ~parity_inj_n;
            rd_par[i] = ^rd_word[i*8 +: 8];
        end
        par_mismatch = gnt & ~acc_we & in_range & (|(rd_par ^ par_mem[acc_addr]));
    end

    always_ff @(posedge clk) begin
        if (gnt && acc_we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (acc_be[i]) par_mem[acc_addr][i] <= wr_par[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            parity_err <= 1'b0;
        else if (par_mismatch) parity_err <= 1'b1;
        else if (err_clr)      parity_err <= 1'b0;
    end
`else
    logic unused_parity_inj;
    assign unused_parity_inj = parity_inj_n;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_arb_dual_port_ram.sv
// Scoreboard bench for arb_dual_port_ram: the driver queues expected read data, and a negedge monitor pops and compares it on rvalid.
// Build with RAM_PARITY_EN defined to exercise the parity fault-injection path.
module tb_arb_dual_port_ram;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1000;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [3:0]        a_be = 0, b_be = 0;
    logic [ADDR_W-1:0] a_addr = 0, b_addr = 0;
    logic [DATA_W-1:0] a_wdata = 0, b_wdata = 0;
    logic              a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              oob_err, parity_err;
    logic              err_clr = 0, parity_inj_n = 1;
    logic [CNT_W-1:0]  conflict_cnt;

    int checks = 0, errors = 0, cycle = 0;
    int a_seen = 0, b_seen = 0, a_base, b_base;

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t qa[$], qb[$];

    arb_dual_port_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .oob_err(oob_err), .err_clr(err_clr), .conflict_cnt(conflict_cnt),
        .parity_err(parity_err), .parity_inj_n(parity_inj_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // An entry is due exactly one cycle after its granting edge; anything else is a timing error.
    always @(negedge clk) begin
        if (rst_n) begin
            logic ev;
            exp_t e;
            ev = (qa.size() > 0) && (qa[0].due == cycle);
            if (a_rvalid || ev) begin
                checkOutput("a_rvalid", a_rvalid, ev);
                if (ev) begin
                    e = qa.pop_front();
                    if (a_rvalid) checkOutput("a_rdata", a_rdata, e.data);
                end
            end
            if (a_rvalid) a_seen++;
            ev = (qb.size() > 0) && (qb[0].due == cycle);
            if (b_rvalid || ev) begin
                checkOutput("b_rvalid", b_rvalid, ev);
                if (ev) begin
                    e = qb.pop_front();
                    if (b_rvalid) checkOutput("b_rdata", b_rdata, e.data);
                end
            end
            if (b_rvalid) b_seen++;
        end
    end

    task automatic applyStimulus(
        input logic ar, input logic aw, input logic [3:0] abe, input logic [ADDR_W-1:0] aaddr, input logic [31:0] awd,
        input logic br, input logic bw, input logic [3:0] bbe, input logic [ADDR_W-1:0] baddr, input logic [31:0] bwd,
        input logic exp_ag, input logic exp_bg, input logic [31:0] aexp, input logic [31:0] bexp);
        a_req = ar; a_we = aw; a_be = abe; a_addr = aaddr; a_wdata = awd;
        b_req = br; b_we = bw; b_be = bbe; b_addr = baddr; b_wdata = bwd;
        @(negedge clk);
        checkOutput("a_gnt", a_gnt, exp_ag);
        checkOutput("b_gnt", b_gnt, exp_bg);
        if (exp_ag && !aw) qa.push_back('{data: aexp, due: cycle + 1});
        if (exp_bg && !bw) qb.push_back('{data: bexp, due: cycle + 1});
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
    endtask

    task automatic aWrite(input logic [ADDR_W-1:0] addr, input logic [3:0] be, input logic [31:0] data);
        applyStimulus(1, 1, be, addr, data, 0, 0, 4'h0, '0, 32'h0, 1, 0, 32'h0, 32'h0);
    endtask

    task automatic aRead(input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        applyStimulus(1, 0, 4'h0, addr, 32'h0, 0, 0, 4'h0, '0, 32'h0, 1, 0, exp, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset a_rvalid", a_rvalid, 0);
        checkOutput("reset b_rvalid", b_rvalid, 0);
        checkOutput("reset a_rdata", a_rdata, 0);
        checkOutput("reset b_rdata", b_rdata, 0);
        checkOutput("reset oob_err", oob_err, 0);
        checkOutput("reset conflict_cnt", conflict_cnt, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        $display("[TB] basic write/read");
        aWrite(5, 4'hF, 32'hDEADBEEF);
        aRead(5, 32'hDEADBEEF);
        idle(2);
        checkOutput("a_rdata hold", a_rdata, 32'hDEADBEEF);

        $display("[TB] byte strobes");
        aWrite(7, 4'hF, 32'h11223344);
        aWrite(7, 4'b0101, 32'hAABBCCDD);
        aRead(7, 32'h11BB33DD);
        idle(1);

        $display("[TB] round-robin conflict");
        aWrite(1, 4'hF, 32'h01010101);
        aWrite(2, 4'hF, 32'h02020202);
        idle(1);
        a_base = a_seen; b_base = b_seen;
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, 4'h0, 1, 32'h0, 1, 0, 4'h0, 2, 32'h0,
                          (i % 2) == 0, (i % 2) == 1, 32'h01010101, 32'h02020202);
        idle(2);
        checkOutput("conflict_cnt after 4", conflict_cnt, 4);
        checkOutput("a rvalid count", a_seen - a_base, 2);
        checkOutput("b rvalid count", b_seen - b_base, 2);

        $display("[TB] out of range");
        aRead(10'd1000, 32'h0);
        checkOutput("oob_err set", oob_err, 1);
        err_clr = 1;
        idle(1);
        err_clr = 0;
        checkOutput("oob_err cleared", oob_err, 0);
        err_clr = 1;
        aRead(10'd1000, 32'h0);
        err_clr = 0;
        checkOutput("oob_err set beats clear", oob_err, 1);
        err_clr = 1;
        idle(1);
        err_clr = 0;
        checkOutput("oob_err cleared again", oob_err, 0);
        checkOutput("conflict_cnt kept by err_clr", conflict_cnt, 4);

        $display("[TB] counter saturation");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(1, 1, 4'h0, 5, 32'hFFFFFFFF, 1, 1, 4'h0, 6, 32'hFFFFFFFF,
                          (i % 2) == 0, (i % 2) == 1, 32'h0, 32'h0);
            if (i == 9) checkOutput("conflict_cnt at 14", conflict_cnt, 14);
        end
        checkOutput("conflict_cnt saturated", conflict_cnt, 15);
        aRead(5, 32'hDEADBEEF);
        idle(1);

`ifdef RAM_PARITY_EN
        $display("[TB] parity injection");
        checkOutput("parity_err clean", parity_err, 0);
        parity_inj_n = 0;
        aWrite(20, 4'hF, 32'h5A5A5A5A);
        parity_inj_n = 1;
        aRead(20, 32'h5A5A5A5A);
        checkOutput("parity_err set", parity_err, 1);
        idle(1);
`else
        checkOutput("parity_err tied low", parity_err, 0);
`endif

        $display("[TB] reset mid-operation");
        aRead(10'd1000, 32'h0);
        idle(1);
        a_req = 1; a_we = 0; a_addr = 5;
        @(negedge clk);
        checkOutput("a_gnt before reset", a_gnt, 1);
        @(posedge clk); #1;
        rst_n = 0;
        a_req = 0;
        #1;
        checkOutput("reset drops a_rvalid", a_rvalid, 0);
        checkOutput("reset clears a_rdata", a_rdata, 0);
        checkOutput("reset clears oob_err", oob_err, 0);
        checkOutput("reset clears conflict_cnt", conflict_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        idle(2);
        applyStimulus(1, 0, 4'h0, 1, 32'h0, 1, 0, 4'h0, 2, 32'h0, 1, 0, 32'h01010101, 32'h0);
        idle(2);

        checkOutput("port A reads outstanding", qa.size(), 0);
        checkOutput("port B reads outstanding", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
